// File: rtl/arith_left_shift_unit.sv
// Multi-cycle arithmetic left shifter: one bit per clock, with a sticky
// signed-overflow flag and the last bit shifted out of the MSB.
module arith_left_shift_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [CNT_W-1:0] amount,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             overflow,
    output logic             carry
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf;
    logic             ovf_nxt;
    logic             cry;
    logic             cry_nxt;
    logic             accept;

    assign accept = (state == IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            cry   <= 1'b0;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
            cry   <= cry_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        cry_nxt   = cry;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    sreg_nxt  = in;
                    cnt_nxt   = amount;
                    ovf_nxt   = 1'b0;
                    cry_nxt   = 1'b0;
                    state_nxt = (amount != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
                cry_nxt  = sreg[WIDTH-1];
                // Sign changes whenever the two top bits differ before a shift
                ovf_nxt  = ovf | (sreg[WIDTH-1] ^ sreg[WIDTH-2]);
                cnt_nxt  = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign ready    = (state == IDLE);
    assign busy     = (state == SHIFT);
    assign done     = (state == DONE);
    assign out      = sreg;
    assign overflow = ovf;
    assign carry    = cry;

endmodule
